sng_stream_ctrl: RTL and testbench

//  Sequencer for one stochastic number generator lane: accepts a binary operand over a

---
 rtl/sng_stream_ctrl.sv | 97 +++++++++
 tb/tb_sng_stream_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sng_stream_ctrl.sv
// Stochastic number generator lane sequencer: latches one operand, then emits a full-period
// LFSR comparator stream (bit = lfsr <= operand) under valid/ready backpressure.
//  state | meaning
//  IDLE  | waiting for an operand, in_ready high
//  RUN   | streaming bits, bit_valid high, cnt = index of the presented bit
module sng_stream_ctrl #(
   parameter int unsigned              PRECISION = 8,
   parameter logic [PRECISION-1:0]     TAPS      = 8'hB8,
   parameter logic [PRECISION-1:0]     SEED      = 8'h01,
   parameter bit                       RESEED    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PRECISION-1:0] in_data,
   input  logic                 abort,
   output logic                 bit_valid,
   input  logic                 bit_ready,
   output logic                 bit_out,
   output logic                 bit_last,
   output logic                 busy,
   output logic                 done
);

   // An all-zero seed would lock the LFSR, so it is quietly promoted to 1.
   localparam logic [PRECISION-1:0] SEED_EFF =
      (SEED == '0) ? {{(PRECISION-1){1'b0}}, 1'b1} : SEED;
   localparam logic [PRECISION-1:0] LAST_IDX = {{(PRECISION-1){1'b1}}, 1'b0};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t               state, state_nxt;
   logic [PRECISION-1:0] lfsr;
   logic [PRECISION-1:0] val_q;
   logic [PRECISION-1:0] cnt;
   logic                 accept;
   logic                 fire;
   logic                 last_fire;

   assign accept    = (state == IDLE) && in_valid;
   // abort wins over a same-cycle handshake: the bit is dropped, not counted
   assign fire      = (state == RUN) && bit_ready && !abort;
   assign last_fire = fire && (cnt == LAST_IDX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept)                state_nxt = RUN;
         RUN:  if (abort || last_fire)    state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr  <= SEED_EFF;
         val_q <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= last_fire;
         if (accept) begin
            val_q <= in_data;
            cnt   <= '0;
            if (RESEED) lfsr <= SEED_EFF;
         end else if (fire) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
            cnt  <= last_fire ? '0 : cnt + 1'b1;
         end
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      bit_valid = 1'b0;
      bit_out   = 1'b0;
      bit_last  = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         RUN: begin
            bit_valid = 1'b1;
            busy      = 1'b1;
            bit_out   = (lfsr <= val_q);
            bit_last  = (cnt == LAST_IDX);
         end
         default: in_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_sng_stream_ctrl.sv
// Bench for sng_stream_ctrl: a reseeding lane (u0) and a free-running lane (u1) share stimulus
// and are compared against an LFSR sequence model plus the "stream holds operand ones" rule.
module tb_sng_stream_ctrl;

   localparam logic [7:0] SEED = 8'h01;
   localparam int         L    = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       abort = 1'b0;
   logic       bit_ready = 1'b0;

   logic in_ready0, bit_valid0, bit_out0, bit_last0, busy0, done0;
   logic in_ready1, bit_valid1, bit_out1, bit_last1, busy1, done1;

   sng_stream_ctrl #(.PRECISION(8), .TAPS(8'hB8), .SEED(SEED), .RESEED(1'b1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .abort(abort), .bit_valid(bit_valid0), .bit_ready(bit_ready), .bit_out(bit_out0),
      .bit_last(bit_last0), .busy(busy0), .done(done0));

   sng_stream_ctrl #(.PRECISION(8), .TAPS(8'hB8), .SEED(SEED), .RESEED(1'b0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .abort(abort), .bit_valid(bit_valid1), .bit_ready(bit_ready), .bit_out(bit_out1),
      .bit_last(bit_last1), .busy(busy1), .done(done1));

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] m0, m1;
   bit         pend;

   typedef struct {
      int op;
      int stall;
      int cut_at;
      int cut_kind;   // 0 full stream, 1 abort, 2 reset
      int exp_ones;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] nxt(input logic [7:0] x);
      return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
   endfunction

   task automatic check_reset_outputs();
      check("rst_in_ready", in_ready0, 1);
      check("rst_bit_valid", bit_valid0, 0);
      check("rst_bit_out", bit_out0, 0);
      check("rst_bit_last", bit_last0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_in_ready_u1", in_ready1, 1);
      check("rst_bit_valid_u1", bit_valid1, 0);
   endtask

   task automatic start(input int op);
      int w;
      bit was_pend;
      @(negedge clk);
      was_pend = pend;
      check("done_pulse", done0, pend);
      check("done_pulse_u1", done1, pend);
      pend = 1'b0;
      bit_ready = 1'b0;
      w = 0;
      while (!in_ready0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_wait", in_ready0, 1);
      if (was_pend) check("b2b_gap", w, 0);
      in_valid = 1'b1;
      in_data  = op[7:0];
      m0 = SEED;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic body(input int op, input int stall, input int cut_at, input int cut_kind,
                       output int ones0, output int ones1);
      int idx;
      bit rdy;
      idx = 0;
      ones0 = 0;
      ones1 = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         check("bit_valid", bit_valid0, 1);
         check("bit_valid_u1", bit_valid1, 1);
         check("busy", busy0, 1);
         check("in_ready_run", in_ready0, 0);
         check("done_run", done0, 0);
         check("bit_out", bit_out0, (m0 <= op[7:0]));
         check("bit_out_u1", bit_out1, (m1 <= op[7:0]));
         check("bit_last", bit_last0, (idx == L - 1));
         if (idx == cut_at && cut_kind == 1) begin
            abort = 1'b1;
            bit_ready = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            in_valid = 1'b0;
            bit_ready = 1'b0;
            check("abort_bit_valid", bit_valid0, 0);
            check("abort_in_ready", in_ready0, 1);
            check("abort_done", done0, 0);
            check("abort_busy", busy0, 0);
            check("abort_bit_valid_u1", bit_valid1, 0);
            return;
         end
         if (idx == cut_at && cut_kind == 2) begin
            bit_ready = 1'b1;
            rst = 1'b0;
            #1;
            check_reset_outputs();
            @(negedge clk);
            rst = 1'b1;
            bit_ready = 1'b0;
            m0 = SEED;
            m1 = SEED;
            return;
         end
         rdy = ($urandom_range(99) >= stall);
         bit_ready = rdy;
         if (rdy) begin
            ones0 += int'(bit_out0);
            ones1 += int'(bit_out1);
            m0 = nxt(m0);
            m1 = nxt(m1);
            idx++;
            if (idx == L) begin
               pend = 1'b1;
               return;
            end
         end
         @(negedge clk);
      end
      check("stream_timeout", idx, L);
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      int   o0, o1;
      vecs.push_back('{op: 0,   stall: 0,  cut_at: -1, cut_kind: 0, exp_ones: 0});
      vecs.push_back('{op: 255, stall: 0,  cut_at: -1, cut_kind: 0, exp_ones: 255});
      vecs.push_back('{op: 128, stall: 0,  cut_at: -1, cut_kind: 0, exp_ones: 128});
      vecs.push_back('{op: 100, stall: 50, cut_at: -1, cut_kind: 0, exp_ones: 100});
      vecs.push_back('{op: 77,  stall: 0,  cut_at: 10, cut_kind: 1, exp_ones: -1});
      vecs.push_back('{op: 200, stall: 0,  cut_at: -1, cut_kind: 0, exp_ones: 200});
      vecs.push_back('{op: 50,  stall: 0,  cut_at: -1, cut_kind: 0, exp_ones: 50});
      vecs.push_back('{op: 60,  stall: 0,  cut_at: -1, cut_kind: 0, exp_ones: 60});
      vecs.push_back('{op: 90,  stall: 20, cut_at: 30, cut_kind: 2, exp_ones: -1});
      vecs.push_back('{op: 33,  stall: 30, cut_at: -1, cut_kind: 0, exp_ones: 33});
      for (int i = 0; i < 5; i++) begin
         int r;
         r = int'($urandom_range(255));
         vecs.push_back('{op: r, stall: int'($urandom_range(70)), cut_at: -1, cut_kind: 0,
                          exp_ones: r});
      end

      m0 = SEED;
      m1 = SEED;
      pend = 1'b0;
      #12;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b1;

      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_in_ready", in_ready0, 1);
      check("idle_abort_busy", busy0, 0);

      foreach (vecs[i]) begin
         start(vecs[i].op);
         body(vecs[i].op, vecs[i].stall, vecs[i].cut_at, vecs[i].cut_kind, o0, o1);
         if (vecs[i].cut_kind == 0) begin
            check($sformatf("ones_op%0d", vecs[i].op), o0, vecs[i].exp_ones);
            check($sformatf("ones_u1_op%0d", vecs[i].op), o1, vecs[i].exp_ones);
         end
      end

      @(negedge clk);
      check("final_done", done0, pend);
      check("final_in_ready", in_ready0, 1);
      check("final_bit_valid", bit_valid0, 0);
      @(negedge clk);
      check("final_done_clear", done0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
